mlaccel_smem_arbiter: RTL
=========================

Name: mlaccel_smem_arbiter

Overview:
- Shares the single-port sequencer/code memory (SMEM) between three requesters: host (read/write), sequencer instruction fetch (read-only), and compute unit (read/write).
- Round-robin arbitration; one memory access issued per cycle; at most one outstanding access per requester.
- Requester side uses the valid/ready protocol the sequencer fetch port already speaks: valid and addr held until a one-cycle ready pulse, with read data valid in that same cycle.

Parameters:
ADDR_W, 16, SMEM word address width
DATA_W, 32, SMEM word width
RD_LATENCY, 1, cycles from mem_en to mem_rdata valid (legal 1..3)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
host_valid  in  1  host request
host_ready  out  1  host completion pulse
host_write  in  1  1=write, 0=read
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  read data, valid when host_ready and read
seq_valid  in  1  sequencer fetch request
seq_ready  out  1  fetch completion pulse
seq_addr  in  ADDR_W  fetch word address
seq_rdata  out  DATA_W  fetched word, valid with seq_ready
comp_valid  in  1  compute request
comp_ready  out  1  compute completion pulse
comp_write  in  1  1=write, 0=read
comp_addr  in  ADDR_W  compute word address
comp_wdata  in  DATA_W  compute write data
comp_rdata  out  DATA_W  read data, valid when comp_ready and read
mem_en  out  1  SMEM access strobe (registered)
mem_we  out  1  SMEM write enable (registered)
mem_addr  out  ADDR_W  SMEM address (registered)
mem_wdata  out  DATA_W  SMEM write data (registered)
mem_rdata  in  DATA_W  SMEM read data, RD_LATENCY cycles after mem_en
busy  out  1  any access pending or in flight

Behaviour:
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all *_ready=0, busy=0. Round-robin pointer=host. Pending flags and in-flight pipe cleared.
- Port index: host=0, seq=1, comp=2. Per-port pending flag is set on grant and cleared at the clock edge ending that port's ready cycle.
- Eligibility: valid && !pending. Ready cycle: pending is still 1 there, so the still-high valid is never regranted.
- A requester may present a new request in the cycle immediately after its ready.
- Arbitration (combinational, each cycle): pick the first eligible port starting at the pointer, wrapping 0→1→2→0. On grant, pointer := granted+1 mod 3. No grant leaves the pointer unchanged.
- Issue: the granted port's write/addr/wdata are registered onto mem_*, with mem_en=1 for exactly one cycle (the issue cycle). seq issues always have mem_we=0. No grant gives mem_en=0; mem_addr/mem_wdata hold their last value.
- Write completion: the granted port's ready is asserted in the issue cycle (registered together with mem_en).
- Read completion: a tag shift register of depth RD_LATENCY, each entry {valid, port[1:0]}, is loaded at issue. When the tail is valid, that port's ready is asserted and mem_rdata is presented.
- Latency, uncontended, valid rising in cycle 0: write ready in cycle 1; read ready in cycle 1+RD_LATENCY.
- host_rdata, seq_rdata and comp_rdata are all driven directly from mem_rdata; they are meaningful only with the matching ready.
- Simultaneous events:
  - One port's write ready and another port's read ready may coincide.
  - The same port can never receive two readies in one cycle.
  - A new grant may issue in the same cycle as any completion.
- Ordering: memory order equals issue order. A read issued after a write to the same address returns the new data.
- busy = any pending flag set or any in-flight tag valid (registered).
- Requester rule: valid/addr/write/wdata held stable until ready. Dropping valid before ready is illegal (behaviour undefined; bench assertion flags it).
- Reset mid-operation: in-flight reads are discarded with no ready pulse, pending flags are cleared, and the pointer returns to host. Requests still valid after reset deasserts are arbitrated as new requests.

Test Plan:
- RD_LATENCY=1. Single seq read of addr 0x0010 with mem word 0xDEADBEEF → mem_en in cycle 1 with addr 0x0010; seq_ready=1 with seq_rdata 0xDEADBEEF in cycle 2 only.
- All three valid in cycle 0 (host write 0x0004←0x11111111, seq read 0x0004, comp read 0x0008) → issue order host, seq, comp in cycles 1,2,3; seq reads 0x11111111; pointer back at host.
- seq re-requests immediately after each ready while comp is continuously valid → grants alternate seq/comp; neither port waits more than 2 issue slots.
- RD_LATENCY=3. host read then comp write back-to-back → comp_ready in cycle 2, host_ready in cycle 4; no double ready.
- reset asserted the cycle after a seq read issues, RD_LATENCY=2 → no seq_ready, busy=0 after reset. seq_valid still high is regranted: mem_en in the first cycle after reset deasserts.
- Write ready cycle with valid still high → no second mem_en for that port; a new write presented the next cycle issues exactly once.

Source files
------------

// File: rtl/mlaccel_smem_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : mlaccel_smem_arbiter
// Brief    : round-robin sharing of the single-port SMEM by host, sequencer
//            fetch and compute, with a read-tag pipe matching RD_LATENCY
// Revision : 1.0
// ==========================================================================
module mlaccel_smem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              seq_valid,
  output logic              seq_ready,
  input  logic [ADDR_W-1:0] seq_addr,
  output logic [DATA_W-1:0] seq_rdata,
  input  logic              comp_valid,
  output logic              comp_ready,
  input  logic              comp_write,
  input  logic [ADDR_W-1:0] comp_addr,
  input  logic [DATA_W-1:0] comp_wdata,
  output logic [DATA_W-1:0] comp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] C_HOST = 2'd0;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Four-entry views so a 2-bit port index never selects out of range
  logic [3:0]        w_elig;
  logic [3:0]        w_write;
  logic [ADDR_W-1:0] w_addr  [4];
  logic [DATA_W-1:0] w_wdata [4];
  logic [1:0]        w_cand0, w_cand1, w_cand2;
  logic              w_grant;
  logic [1:0]        w_grant_idx;
  logic [2:0]        w_grant_oh;
  logic [2:0]        w_rd_ready;
  logic [2:0]        w_ready;

  logic [1:0]            r_ptr;
  logic [2:0]            r_pending;
  logic [2:0]            r_wr_ready;
  logic [1:0]            r_issue_port;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [1:0]            r_tag_port [RD_LATENCY];

  assign w_elig     = {1'b0, {comp_valid, seq_valid, host_valid} & ~r_pending};
  assign w_write    = {1'b0, comp_write, 1'b0, host_write};
  assign w_addr[0]  = host_addr;
  assign w_addr[1]  = seq_addr;
  assign w_addr[2]  = comp_addr;
  assign w_addr[3]  = '0;
  assign w_wdata[0] = host_wdata;
  assign w_wdata[1] = '0;
  assign w_wdata[2] = comp_wdata;
  assign w_wdata[3] = '0;

  // Search order starts at the pointer and wraps host -> seq -> comp
  always_comb begin
    w_cand0     = r_ptr;
    w_cand1     = f_inc(r_ptr);
    w_cand2     = f_inc(w_cand1);
    w_grant     = 1'b1;
    w_grant_idx = w_cand0;
    if (w_elig[w_cand0]) begin
      w_grant_idx = w_cand0;
    end else if (w_elig[w_cand1]) begin
      w_grant_idx = w_cand1;
    end else if (w_elig[w_cand2]) begin
      w_grant_idx = w_cand2;
    end else begin
      w_grant = 1'b0;
    end
  end

  assign w_grant_oh = w_grant ? (3'b001 << w_grant_idx) : 3'b000;
  assign w_rd_ready = r_tag_v[RD_LATENCY-1] ? (3'b001 << r_tag_port[RD_LATENCY-1]) : 3'b000;
  assign w_ready    = r_wr_ready | w_rd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr        <= C_HOST;
      r_pending    <= '0;
      r_wr_ready   <= '0;
      r_issue_port <= C_HOST;
      r_tag_v      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_tag_port[i] <= C_HOST;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_ready) | w_grant_oh;
      mem_en     <= w_grant;
      mem_we     <= w_grant && w_write[w_grant_idx];
      r_wr_ready <= (w_grant && w_write[w_grant_idx]) ? w_grant_oh : 3'b000;
      if (w_grant) begin
        r_ptr        <= f_inc(w_grant_idx);
        mem_addr     <= w_addr[w_grant_idx];
        mem_wdata    <= w_wdata[w_grant_idx];
        r_issue_port <= w_grant_idx;
      end
      // Tag enters behind the issue cycle so the tail lines up with mem_rdata
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_port[i] <= r_tag_port[i-1];
      end
      r_tag_v[0]    <= mem_en && !mem_we;
      r_tag_port[0] <= r_issue_port;
    end
  end

  assign host_ready = w_ready[0];
  assign seq_ready  = w_ready[1];
  assign comp_ready = w_ready[2];
  assign host_rdata = mem_rdata;
  assign seq_rdata  = mem_rdata;
  assign comp_rdata = mem_rdata;
  assign busy       = (|r_pending) || (|r_tag_v);

endmodule
`default_nettype wire
